psum_column_drain: RTL and testbench
====================================

Name: psum_column_drain

Overview:
- Downstream stage of one PE column in the systolic array.
- After the column's PEs raise their finish flags, it walks the per-PE output-select chain one row at a time and samples each accumulated partial sum.
- Each sample is bias-added, optionally ReLU'd, arithmetically right-shifted and saturated back to DW bits.
- Results are queued in a FIFO with a valid/ready output toward the output-feature-map buffer.

Parameters:
DW, 8, activation/weight width; column psums are 2*DW signed
ROWS, 4, PEs per column (rows drained per burst)
FIFO_DEPTH, 8, output FIFO entries; must be >= ROWS
SHIFT_W, 4, width of requantisation shift amount
ROW_W, 2, width of row index (>= clog2(ROWS))

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
start  in  1  one-cycle pulse: column psums are final, begin drain
bias  in  2*DW  signed bias, latched on accepted start
shift  in  SHIFT_W  right-shift amount, latched on accepted start
relu_en  in  1  clamp negatives to 0, latched on accepted start
clr_ovr  in  1  clears overrun flag
pe_sel  out  ROWS  per-PE sel; bit r drives sel of row r (row 0 nearest this block)
col_data  in  2*DW  signed chained out_data from bottom PE of column
out_data  out  DW  signed requantised result (FIFO head)
out_row  out  ROW_W  row index of out_data
out_valid  out  1  FIFO non-empty
out_ready  in  1  consumer accepts head
busy  out  1  state != IDLE
done  out  1  one-cycle pulse when last result of burst written to FIFO
overrun  out  1  sticky: start seen while not IDLE

Behaviour:
- Clock is clk. Reset is synchronous, active-low (rst_n sampled on clk). Reset forces every output and internal register to 0: state IDLE, FIFO empty, pe_sel=0, out_valid=0, done=0, overrun=0.
- Reset mid-burst discards the burst and all FIFO contents.
- FSM states: IDLE, WAIT_SPACE, DRAIN, FLUSH.
- IDLE, start=1: latch bias/shift/relu_en.
  - If FIFO_DEPTH-count >= ROWS, go to DRAIN.
  - Otherwise go to WAIT_SPACE.
- WAIT_SPACE: move to DRAIN in the first cycle free space >= ROWS (pops only).
- DRAIN: row counter r runs 0..ROWS-1, one row per cycle, no stalls.
  - pe_sel is registered and one-hot (1<<r); all other bits 0, so lower PEs pass in_pre through.
  - col_data is captured into stage S1 at the end of each DRAIN cycle, tagged with r.
  - After r=ROWS-1, go to FLUSH.
- FLUSH: pe_sel=0. Hold 2 cycles until S2/S3 drain. On the last S3 write, pulse done and go to IDLE.
- Pipeline:
  - S1: capture.
  - S2: sum = col_data + bias, width 2*DW+1, sign-extended, no overflow.
  - S3: if relu_en and sum<0, sum=0. Then v = sum >>> shift (arithmetic). Saturate v to [-2^(DW-1), 2^(DW-1)-1]. Push {v, row} to FIFO.
  - Shift values >= 2*DW+1 yield 0 or -1 per sign.
- Latency: start accepted at cycle 0 edge → pe_sel row 0 in cycle 1 → FIFO write at end of cycle 3 → out_valid high in cycle 4 (FIFO initially empty). Thereafter one result per cycle.
- FIFO:
  - Registered head; out_valid = !empty.
  - Pop on out_valid & out_ready.
  - Space reservation guarantees no push when full.
  - Simultaneous push and pop keeps count unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- start while busy: ignored (no relatch, burst unaffected), overrun<=1.
- clr_ovr clears overrun. If clr_ovr and a new overrun coincide, overrun stays 1.
- start and done in the same cycle: start is treated as busy → overrun.

Optional Feature:
- Macro DRAIN_ROUND_EN.
- Defined: S3 adds 2^(shift-1) before the shift when shift>0 (round half up). S2/S3 width grows to 2*DW+2.
- Undefined: pure truncating arithmetic shift; no extra adder.

Test Plan:
- Test 1: DW=8, ROWS=4, bias=0, shift=0, relu off; PE psums rows0..3 = 100, -50, 300, -3000; start → out_data 100, -50, 127, -128 with out_row 0..3. First out_valid exactly 4 cycles after start; done pulses once.
- Test 2: bias=6, shift=2, relu on; psums 10, -20, 1000, 3 → out_data 4, 0, 127, 2.
- Test 3: out_ready=0.
  - Burst 1 accepted (count 4).
  - Burst 2 accepted (count 8).
  - Third start → busy=1 in WAIT_SPACE, pe_sel stays 0.
  - Raise out_ready for 4 pops → third burst drains.
  - All 12 results in order.
- Test 4: start pulse during DRAIN → overrun=1, burst still yields 4 correct results. clr_ovr → overrun=0.
- Test 5: rst_n low during DRAIN row 2 → next cycle pe_sel=0, out_valid=0, busy=0. Next start drains normally.
- Test 6: psum 6, bias 0, shift 2 → out_data 2 with DRAIN_ROUND_EN defined, 1 without.

Source files
------------

// File: rtl/psum_column_drain.sv
// Column drain stage: walks the PE output-select chain, requantises each psum and queues it toward the OFM buffer.
// Optional macro DRAIN_ROUND_EN enables round-half-up before the requantisation shift.
module psum_column_drain #(
  parameter int DW         = 8,
  parameter int ROWS       = 4,
  parameter int FIFO_DEPTH = 8,
  parameter int SHIFT_W    = 4,
  parameter int ROW_W      = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [2*DW-1:0]     bias,
  input  logic [SHIFT_W-1:0]  shift,
  input  logic                relu_en,
  input  logic                clr_ovr,
  output logic [ROWS-1:0]     pe_sel,
  input  logic [2*DW-1:0]     col_data,
  output logic [DW-1:0]       out_data,
  output logic [ROW_W-1:0]    out_row,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                busy,
  output logic                done,
  output logic                overrun
);

  localparam int PW = 2*DW;
`ifdef DRAIN_ROUND_EN
  localparam int SW = 2*DW + 2;
`else
  localparam int SW = 2*DW + 1;
`endif
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic signed [SW-1:0] SAT_MAX = SW'((2**(DW-1)) - 1);
  localparam logic signed [SW-1:0] SAT_MIN = ~SAT_MAX;

  typedef enum logic [1:0] {IDLE, WAIT_SPACE, DRAIN, FLUSH} state_t;

  state_t                    r_state;
  logic [ROW_W-1:0]          r_row;
  logic [ROWS-1:0]           r_pe_sel;
  logic signed [PW-1:0]      r_bias;
  logic [SHIFT_W-1:0]        r_shift;
  logic                      r_relu;
  logic                      r_flush_cnt;
  logic                      r_done;
  logic                      r_ovr;

  logic signed [PW-1:0]      r_s1_data;
  logic [ROW_W-1:0]          r_s1_row;
  logic                      r_s1_vld;
  logic signed [SW-1:0]      r_s2_sum;
  logic [ROW_W-1:0]          r_s2_row;
  logic                      r_s2_vld;

  logic [DW-1:0]             r_mem_data [FIFO_DEPTH];
  logic [ROW_W-1:0]          r_mem_row  [FIFO_DEPTH];
  logic [AW-1:0]             r_wptr;
  logic [AW-1:0]             r_rptr;
  logic [CW-1:0]             r_count;

  logic                      w_space_ok;
  logic                      w_push;
  logic                      w_pop;
  logic signed [SW-1:0]      w_relu;
  logic signed [SW-1:0]      w_rnd;
  logic signed [SW-1:0]      w_shf;
  logic [DW-1:0]             w_q;

  assign w_space_ok = (r_count <= CW'(FIFO_DEPTH - ROWS));
  assign w_push     = r_s2_vld;
  assign w_pop      = (r_count != '0) && out_ready;

  assign pe_sel    = r_pe_sel;
  assign busy      = (r_state != IDLE);
  assign done      = r_done;
  assign overrun   = r_ovr;
  assign out_valid = (r_count != '0);
  assign out_data  = r_mem_data[r_rptr];
  assign out_row   = r_mem_row[r_rptr];

  // Control FSM; done is scheduled one cycle early so it coincides with the last FIFO write.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_row       <= '0;
      r_pe_sel    <= '0;
      r_bias      <= '0;
      r_shift     <= '0;
      r_relu      <= 1'b0;
      r_flush_cnt <= 1'b0;
      r_done      <= 1'b0;
      r_ovr       <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_bias  <= $signed(bias);
            r_shift <= shift;
            r_relu  <= relu_en;
            r_row   <= '0;
            if (w_space_ok) begin
              r_state  <= DRAIN;
              r_pe_sel <= ROWS'(1);
            end else begin
              r_state  <= WAIT_SPACE;
            end
          end
        end
        WAIT_SPACE: begin
          if (w_space_ok) begin
            r_state  <= DRAIN;
            r_pe_sel <= ROWS'(1);
            r_row    <= '0;
          end
        end
        DRAIN: begin
          if (r_row == ROW_W'(ROWS - 1)) begin
            r_state     <= FLUSH;
            r_pe_sel    <= '0;
            r_flush_cnt <= 1'b0;
          end else begin
            r_row    <= r_row + ROW_W'(1);
            r_pe_sel <= r_pe_sel << 1;
          end
        end
        FLUSH: begin
          if (!r_flush_cnt) begin
            r_flush_cnt <= 1'b1;
            r_done      <= 1'b1;
          end else begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase

      if (start && (r_state != IDLE))
        r_ovr <= 1'b1;
      else if (clr_ovr)
        r_ovr <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s1_data <= '0;
      r_s1_row  <= '0;
      r_s1_vld  <= 1'b0;
      r_s2_sum  <= '0;
      r_s2_row  <= '0;
      r_s2_vld  <= 1'b0;
    end else begin
      r_s1_vld  <= (r_state == DRAIN);
      r_s1_data <= $signed(col_data);
      r_s1_row  <= r_row;
      r_s2_vld  <= r_s1_vld;
      r_s2_sum  <= SW'(r_s1_data) + SW'(r_bias);
      r_s2_row  <= r_s1_row;
    end
  end

  always_comb begin
    w_relu = (r_relu && r_s2_sum[SW-1]) ? '0 : r_s2_sum;
`ifdef DRAIN_ROUND_EN
    w_rnd = w_relu;
    if (r_shift != '0)
      w_rnd = w_relu + $signed(SW'(1) << (r_shift - SHIFT_W'(1)));
`else
    w_rnd = w_relu;
`endif
    w_shf = w_rnd >>> r_shift;
    if (w_shf > SAT_MAX)
      w_q = SAT_MAX[DW-1:0];
    else if (w_shf < SAT_MIN)
      w_q = SAT_MIN[DW-1:0];
    else
      w_q = w_shf[DW-1:0];
  end

  // Space is reserved before a burst starts, so a push never meets a full FIFO.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
        r_mem_data[i] <= '0;
        r_mem_row[i]  <= '0;
      end
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_mem_data[r_wptr] <= w_q;
        r_mem_row[r_wptr]  <= r_s2_row;
        r_wptr <= (r_wptr == AW'(FIFO_DEPTH - 1)) ? '0 : r_wptr + AW'(1);
      end
      if (w_pop)
        r_rptr <= (r_rptr == AW'(FIFO_DEPTH - 1)) ? '0 : r_rptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: tb/tb_psum_column_drain.sv
// Directed bench for psum_column_drain (DW=8, ROWS=4, FIFO_DEPTH=8); PE column modelled as a psum table muxed by pe_sel.
module tb_psum_column_drain;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] bias = '0;
  logic [3:0]  shift = '0;
  logic        relu_en = 1'b0;
  logic        clr_ovr = 1'b0;
  logic [3:0]  pe_sel;
  logic [15:0] col_data;
  logic [7:0]  out_data;
  logic [1:0]  out_row;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        busy;
  logic        done;
  logic        overrun;

  int total = 0;
  int bad = 0;
  int done_cnt = 0;

  logic [15:0] psum [4];
  logic [7:0]  gd [16];
  logic [1:0]  gr [16];

  psum_column_drain #(.DW(8), .ROWS(4), .FIFO_DEPTH(8), .SHIFT_W(4), .ROW_W(2)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .bias(bias), .shift(shift),
    .relu_en(relu_en), .clr_ovr(clr_ovr), .pe_sel(pe_sel), .col_data(col_data),
    .out_data(out_data), .out_row(out_row), .out_valid(out_valid),
    .out_ready(out_ready), .busy(busy), .done(done), .overrun(overrun)
  );

  always #5 clk = ~clk;

  always_comb begin
    col_data = '0;
    for (int i = 0; i < 4; i++)
      if (pe_sel[i]) col_data = psum[i];
  end

  always @(negedge clk) if (done) done_cnt++;

  task automatic set_psum(input int a, input int b, input int c, input int d);
    psum[0] = 16'(a); psum[1] = 16'(b); psum[2] = 16'(c); psum[3] = 16'(d);
  endtask

  task automatic do_start(input int b, input int s, input logic rl);
    @(negedge clk);
    bias = 16'(b); shift = 4'(s); relu_en = rl; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic pop_results(input int n, output int got);
    got = 0;
    out_ready = 1'b1;
    for (int c = 0; c < 200 && got < n; c++) begin
      @(negedge clk);
      if (out_valid) begin
        gd[got] = out_data; gr[got] = out_row; got++;
      end
    end
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (!busy) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++; if (pe_sel !== 4'b0) begin bad++; $display("FAIL reset_pe_sel got=%b want=0000", pe_sel); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", done); end
    total++; if (overrun !== 1'b0) begin bad++; $display("FAIL reset_overrun got=%b want=0", overrun); end
    rst_n = 1'b1;
  endtask

  task automatic test_basic;
    int e[4];
    int got;
    e = '{100, -50, 127, -128};
    set_psum(100, -50, 300, -3000);
    done_cnt = 0;
    do_start(0, 0, 1'b0);
    for (int k = 1; k <= 4; k++) begin
      if (k > 1) begin @(posedge clk); #1; end
      total++;
      if (out_valid !== (k == 4)) begin
        bad++; $display("FAIL basic_latency cycle=%0d got=%b want=%b", k, out_valid, (k == 4));
      end
    end
    pop_results(4, got);
    total++; if (got != 4) begin bad++; $display("FAIL basic_count got=%0d want=4", got); end
    for (int i = 0; i < 4; i++) begin
      total++;
      if (gd[i] !== 8'(e[i]) || gr[i] !== 2'(i)) begin
        bad++; $display("FAIL basic_result[%0d] got=%0d/row%0d want=%0d/row%0d", i, $signed(gd[i]), gr[i], e[i], i);
      end
    end
    total++; if (done_cnt != 1) begin bad++; $display("FAIL basic_done_pulses got=%0d want=1", done_cnt); end
  endtask

  task automatic test_requant;
    int e[4];
    int got;
    e = '{4, 0, 127, 2};
    set_psum(10, -20, 1000, 3);
    do_start(6, 2, 1'b1);
    pop_results(4, got);
    total++; if (got != 4) begin bad++; $display("FAIL requant_count got=%0d want=4", got); end
    for (int i = 0; i < 4; i++) begin
      total++;
      if (gd[i] !== 8'(e[i]) || gr[i] !== 2'(i)) begin
        bad++; $display("FAIL requant_result[%0d] got=%0d/row%0d want=%0d/row%0d", i, $signed(gd[i]), gr[i], e[i], i);
      end
    end
  endtask

  task automatic test_backpressure;
    int e[12];
    int got;
    bit ok;
    e = '{1, 2, 3, 4, -1, -2, -3, -4, 10, 20, 30, 40};
    out_ready = 1'b0;
    set_psum(1, 2, 3, 4);
    do_start(0, 0, 1'b0);
    wait_idle(ok);
    total++; if (!ok) begin bad++; $display("FAIL bp_burst1_idle got=busy want=idle"); end
    set_psum(-1, -2, -3, -4);
    do_start(0, 0, 1'b0);
    wait_idle(ok);
    total++; if (!ok) begin bad++; $display("FAIL bp_burst2_idle got=busy want=idle"); end
    set_psum(10, 20, 30, 40);
    do_start(0, 0, 1'b0);
    repeat (3) begin @(posedge clk); #1; end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL bp_wait_busy got=%b want=1", busy); end
    total++; if (pe_sel !== 4'b0) begin bad++; $display("FAIL bp_wait_pe_sel got=%b want=0000", pe_sel); end
    pop_results(12, got);
    total++; if (got != 12) begin bad++; $display("FAIL bp_count got=%0d want=12", got); end
    for (int i = 0; i < 12; i++) begin
      total++;
      if (gd[i] !== 8'(e[i]) || gr[i] !== 2'(i % 4)) begin
        bad++; $display("FAIL bp_result[%0d] got=%0d/row%0d want=%0d/row%0d", i, $signed(gd[i]), gr[i], e[i], i % 4);
      end
    end
  endtask

  task automatic test_overrun;
    int e[4];
    int got;
    e = '{5, -5, 127, -128};
    set_psum(5, -5, 200, -200);
    do_start(0, 0, 1'b0);
    do_start(100, 3, 1'b1);
    total++; if (overrun !== 1'b1) begin bad++; $display("FAIL ovr_set got=%b want=1", overrun); end
    pop_results(4, got);
    total++; if (got != 4) begin bad++; $display("FAIL ovr_count got=%0d want=4", got); end
    for (int i = 0; i < 4; i++) begin
      total++;
      if (gd[i] !== 8'(e[i]) || gr[i] !== 2'(i)) begin
        bad++; $display("FAIL ovr_result[%0d] got=%0d/row%0d want=%0d/row%0d", i, $signed(gd[i]), gr[i], e[i], i);
      end
    end
    total++; if (overrun !== 1'b1) begin bad++; $display("FAIL ovr_sticky got=%b want=1", overrun); end
    @(negedge clk); clr_ovr = 1'b1;
    @(posedge clk); #1; clr_ovr = 1'b0;
    total++; if (overrun !== 1'b0) begin bad++; $display("FAIL ovr_clear got=%b want=0", overrun); end
  endtask

  task automatic test_reset_mid;
    int e[4];
    int got;
    e = '{7, 8, 9, 10};
    set_psum(7, 8, 9, 10);
    do_start(0, 0, 1'b0);
    repeat (2) begin @(posedge clk); #1; end
    total++; if (pe_sel !== 4'b0100) begin bad++; $display("FAIL rstmid_row2 got=%b want=0100", pe_sel); end
    rst_n = 1'b0;
    @(posedge clk); #1;
    total++; if (pe_sel !== 4'b0) begin bad++; $display("FAIL rstmid_pe_sel got=%b want=0000", pe_sel); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rstmid_out_valid got=%b want=0", out_valid); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rstmid_busy got=%b want=0", busy); end
    rst_n = 1'b1;
    do_start(0, 0, 1'b0);
    pop_results(4, got);
    total++; if (got != 4) begin bad++; $display("FAIL rstmid_count got=%0d want=4", got); end
    for (int i = 0; i < 4; i++) begin
      total++;
      if (gd[i] !== 8'(e[i]) || gr[i] !== 2'(i)) begin
        bad++; $display("FAIL rstmid_result[%0d] got=%0d/row%0d want=%0d/row%0d", i, $signed(gd[i]), gr[i], e[i], i);
      end
    end
  endtask

  task automatic test_round;
    int got;
    int e0;
`ifdef DRAIN_ROUND_EN
    e0 = 2;
`else
    e0 = 1;
`endif
    set_psum(6, 0, 0, 0);
    do_start(0, 2, 1'b0);
    pop_results(4, got);
    total++; if (got != 4) begin bad++; $display("FAIL round_count got=%0d want=4", got); end
    total++;
    if (gd[0] !== 8'(e0)) begin bad++; $display("FAIL round_row0 got=%0d want=%0d", $signed(gd[0]), e0); end
    total++;
    if (gd[1] !== 8'd0) begin bad++; $display("FAIL round_row1 got=%0d want=0", $signed(gd[1])); end
  endtask

  initial begin
    set_psum(0, 0, 0, 0);
    test_reset;
    test_basic;
    test_requant;
    test_backpressure;
    test_overrun;
    test_reset_mid;
    test_round;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
